mult_ctrl: RTL and testbench

Sequencing controller for the shift-add multiplier datapath. It sits directly upstream of the `regs` accumulator/multiplier register and drives its `n_reset` (load), `ADD` and `SHIFT` strobes. The strobes are issued from the register's LSB (`register[0]`) across N iterations, and the controller reports busy/ready/done to the surrounding system through a start/done handshake.

---
 rtl/mult_ctrl.sv | 77 +++++++
 tb/tb_mult_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// mult_ctrl: sequences load/add/shift strobes for an N-iteration shift-add multiplier
module mult_ctrl #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic lsb,
    output logic n_load,
    output logic ADD,
    output logic SHIFT,
    output logic ready,
    output logic done
);
    localparam int CW = $clog2(N);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, ADDS, SHIFTS, DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    // outputs are set from the state being entered, so they stay registered with no input path
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ready  <= 1'b1;
            n_load <= 1'b1;
            ADD    <= 1'b0;
            SHIFT  <= 1'b0;
            done   <= 1'b0;
        end else begin
            ready  <= 1'b0;
            n_load <= 1'b1;
            ADD    <= 1'b0;
            SHIFT  <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        n_load <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= CHECK;
                    cnt   <= '0;
                end
                CHECK: begin
                    if (lsb) begin
                        state <= ADDS;
                        ADD   <= 1'b1;
                    end else begin
                        state <= SHIFTS;
                        SHIFT <= 1'b1;
                    end
                end
                ADDS: begin
                    state <= SHIFTS;
                    SHIFT <= 1'b1;
                end
                SHIFTS: begin
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= CHECK;
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed checks of mult_ctrl strobe timing against a shift-add datapath model
module tb_mult_ctrl;
    logic clk = 1'b0;
    logic reset, start, lsb;
    logic n_load, ADD, SHIFT, ready, done;
    logic [3:0] mult, mcand;
    logic [8:0] dp = '0;
    int vectors = 0;
    int miscompares = 0;
    bit en = 1'b0;
    logic prev_acc = 1'b0;
    logic prev_done = 1'b0;

    mult_ctrl #(.N(4)) dut (
        .clk(clk), .reset(reset), .start(start), .lsb(lsb),
        .n_load(n_load), .ADD(ADD), .SHIFT(SHIFT), .ready(ready), .done(done)
    );

    always #5 clk = ~clk;

    // datapath register: {carry, accumulator[3:0], multiplier[3:0]}
    assign lsb = dp[0];
    always @(posedge clk) begin
        if (!n_load) dp <= {5'b0, mult};
        else if (ADD) dp <= {{1'b0, dp[7:4]} + {1'b0, mcand}, dp[3:0]};
        else if (SHIFT) dp <= dp >> 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            chk("add_shift_excl", int'(ADD & SHIFT), 0);
            if (!n_load) chk("nload_after_start", int'(prev_acc), 1);
            chk("nload_strobe_excl", int'(!n_load & (ADD | SHIFT)), 0);
            chk("done_single", int'(done & prev_done), 0);
        end
        prev_acc  <= ready & start & !reset;
        prev_done <= done;
    end

    task automatic run(input string nm, input logic [3:0] m, input logic [3:0] mc, input logic [31:0] smask,
                       input bit hold, input int exp_done, input logic [31:0] exp_add,
                       input logic [31:0] exp_shift, input int exp_prod);
        logic [31:0] am, sm;
        int dc, dn, rl, pr;
        mult = m; mcand = mc;
        am = '0; sm = '0; dc = -1; dn = 0; rl = 0; pr = -1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= exp_done + 3; k++) begin
            start = hold | smask[k];
            @(negedge clk);
            if (dc < 0) begin
                if (ADD) am[k] = 1'b1;
                if (SHIFT) sm[k] = 1'b1;
                if (!ready) rl++;
                if (k == 1) chk({nm, "_load"}, int'(n_load), 0);
            end
            if (done) begin
                dn++;
                if (dc < 0) begin
                    dc = k;
                    pr = int'(dp);
                end
            end
            if (k == exp_done + 1) chk({nm, "_ready_after"}, int'(ready), 1);
            if (hold && k == exp_done + 2) chk({nm, "_reload"}, int'(n_load), 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({nm, "_done_cycle"}, dc, exp_done);
        chk({nm, "_done_count"}, dn, 1);
        chk({nm, "_add_mask"}, int'(am), int'(exp_add));
        chk({nm, "_shift_mask"}, int'(sm), int'(exp_shift));
        chk({nm, "_busy_cycles"}, rl, exp_done);
        chk({nm, "_product"}, pr, exp_prod);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        reset = 1'b1; start = 1'b1; mult = 4'd0; mcand = 4'd0;
        @(posedge clk); #1;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_n_load", int'(n_load), 1);
        chk("rst_add", int'(ADD), 0);
        chk("rst_shift", int'(SHIFT), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        run("m9", 4'd9, 4'd8, 32'h0, 1'b0, 12, 32'h408, 32'h950, 72);
        run("m0", 4'd0, 4'd8, 32'h0, 1'b0, 10, 32'h0, 32'h2A8, 0);
        run("m15", 4'd15, 4'd8, 32'h0, 1'b0, 14, 32'h1248, 32'h2490, 120);
        run("busy", 4'd9, 4'd5, 32'h88, 1'b0, 12, 32'h408, 32'h950, 45);
        run("hold", 4'd9, 4'd8, 32'h0, 1'b1, 12, 32'h408, 32'h950, 72);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        mult = 4'd9; mcand = 4'd8; dn = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 20; k++) begin
            start = 1'b0;
            reset = (k == 6);
            @(negedge clk);
            if (done) dn++;
            if (k == 7) begin
                chk("abort_ready", int'(ready), 1);
                chk("abort_n_load", int'(n_load), 1);
                chk("abort_shift", int'(SHIFT), 0);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        chk("abort_no_done", dn, 0);
        run("after_rst", 4'd9, 4'd8, 32'h0, 1'b0, 12, 32'h408, 32'h950, 72);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
